fetch_unit: RTL



---
 rtl/fetch_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch front end: drives the instruction-memory address, buffers
// {pc, instr} pairs in a small FIFO and hands them to decode over valid/ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                          clk,
    input  logic                          reset_n,
    output logic [31:0]                   imem_addr_o,
    input  logic [31:0]                   imem_data_i,
    input  logic                          redirect_i,
    input  logic [31:0]                   redirect_pc_i,
    input  logic                          halt_i,
    output logic                          if_valid_o,
    input  logic                          if_ready_i,
    output logic [31:0]                   if_pc_o,
    output logic [31:0]                   if_instr_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t        state_r;
    logic [31:0]   fetch_pc_r;
    logic [31:0]   fifo_pc_r    [FIFO_DEPTH];
    logic [31:0]   fifo_instr_r [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr_r;
    logic [AW-1:0] wr_ptr_r;
    logic [CW-1:0] count_r;

    logic          empty_s;
    logic          full_s;
    logic          valid_s;
    logic          pop_s;
    logic          push_s;
    logic [31:0]   redirect_target_s;
    logic          unused_s;

    // Word-aligned target; the low address bits of a redirect carry no meaning.
    assign redirect_target_s = {redirect_pc_i[31:2], 2'b00};
    assign unused_s          = ^redirect_pc_i[1:0];

    // Handshake and FIFO control decode.
    always_comb begin
        empty_s = (count_r == {CW{1'b0}});
        full_s  = (count_r == CW'(FIFO_DEPTH));
        valid_s = ~empty_s & ~redirect_i;
        pop_s   = valid_s & if_ready_i & ~redirect_i;
        push_s  = (state_r == S_RUN) & ~halt_i & ~redirect_i & (~full_s | pop_s);
    end

    // Decode-facing outputs; a bubble presents a NOP at pc 0.
    always_comb begin
        if_valid_o   = valid_s;
        imem_addr_o  = fetch_pc_r;
        fifo_count_o = count_r;
        if (valid_s) begin
            if_pc_o    = fifo_pc_r[rd_ptr_r];
            if_instr_o = fifo_instr_r[rd_ptr_r];
        end else begin
            if_pc_o    = 32'h0000_0000;
            if_instr_o = NOP_INSTR;
        end
    end

    // Fetch sequencing FSM: one idle boot cycle, then run or halt.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_BOOT;
        end else begin
            case (state_r)
                S_BOOT:  state_r <= halt_i ? S_HALT : S_RUN;
                S_RUN:   if (halt_i && !redirect_i) state_r <= S_HALT;
                S_HALT:  if (!halt_i && !redirect_i) state_r <= S_RUN;
                default: state_r <= S_BOOT;
            endcase
        end
    end

    // Fetch pointer, FIFO pointers and occupancy; a redirect flushes everything.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc_r <= RESET_PC;
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
        end else if (redirect_i) begin
            fetch_pc_r <= redirect_target_s;
            rd_ptr_r   <= {AW{1'b0}};
            wr_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
        end else begin
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            if (push_s) begin
                wr_ptr_r   <= wr_ptr_r + AW'(1);
                fetch_pc_r <= fetch_pc_r + 32'd4;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // FIFO storage; when full with a pop, the tail slot is the one being vacated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pc_r[i]    <= 32'h0000_0000;
                fifo_instr_r[i] <= NOP_INSTR;
            end
        end else if (push_s) begin
            fifo_pc_r[wr_ptr_r]    <= fetch_pc_r;
            fifo_instr_r[wr_ptr_r] <= imem_data_i;
        end
    end

endmodule
